// File: rtl/level_objective_tracker.sv
// Level objective controller: coin collection bitmap, hazard/timeout loss,
// countdown timer and a tile-clear request queue drained one index per handshake.
module level_objective_tracker #(
   parameter int NUM_COINS        = 3,
   parameter int NUM_HAZARDS      = 2,
   parameter int TIME_LIMIT       = 60,
   parameter int TICKS_PER_SECOND = 25_000_000,
   localparam int CIDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1,
   localparam int CNT_W  = $clog2(NUM_COINS + 1),
   localparam int SEC_W  = $clog2(TIME_LIMIT + 1)
) (
   input  logic                   vga_clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [NUM_COINS-1:0]   touch,
   input  logic [NUM_HAZARDS-1:0] hazard_hit,
   input  logic                   clear_ready,
   output logic                   clear_valid,
   output logic [CIDX_W-1:0]      clear_index,
   output logic                   restore,
   output logic [NUM_COINS-1:0]   collected,
   output logic [CNT_W-1:0]       coins_remaining,
   output logic [SEC_W-1:0]       seconds_left,
   output logic [1:0]             state,
   output logic                   win,
   output logic                   lose,
   output logic                   lose_cause
);

   localparam int TICK_W = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_WON  = 2'd2,
      S_LOST = 2'd3
   } state_t;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [CIDX_W-1:0] f_lowest(input logic [NUM_COINS-1:0] v);
      logic [CIDX_W-1:0] idx;
      idx = '0;
      for (int i = NUM_COINS - 1; i >= 0; i--) begin
         if (v[i]) idx = CIDX_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [CNT_W-1:0] f_popcount(input logic [NUM_COINS-1:0] v);
      logic [CNT_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < NUM_COINS; i++) begin
         cnt = cnt + CNT_W'(v[i]);
      end
      return cnt;
   endfunction

   state_t                r_state;
   logic [NUM_COINS-1:0]  r_collected;
   logic [NUM_COINS-1:0]  r_pending;
   logic [SEC_W-1:0]      r_seconds;
   logic [TICK_W-1:0]     r_tick;
   logic                  r_restore;
   logic                  r_lose_cause;

   state_t                w_state_nxt;
   logic [NUM_COINS-1:0]  w_collected_nxt;
   logic [NUM_COINS-1:0]  w_pending_nxt;
   logic [SEC_W-1:0]      w_seconds_nxt;
   logic [TICK_W-1:0]     w_tick_nxt;
   logic                  w_restore_nxt;
   logic                  w_cause_nxt;

   logic                  w_grant;
   logic [NUM_COINS-1:0]  w_grant_mask;
   logic [NUM_COINS-1:0]  w_pending_drained;
   logic [NUM_COINS-1:0]  w_new;
   logic [NUM_COINS-1:0]  w_coll_merged;
   logic                  w_tick_wrap;

   assign clear_valid       = |r_pending;
   assign clear_index       = f_lowest(r_pending);
   assign w_grant           = clear_valid & clear_ready;
   assign w_grant_mask      = w_grant ? (NUM_COINS'(1) << clear_index) : '0;
   assign w_pending_drained = r_pending & ~w_grant_mask;
   assign w_new             = touch & ~r_collected;
   assign w_coll_merged     = r_collected | w_new;
   assign w_tick_wrap       = (r_tick == TICK_W'(TICKS_PER_SECOND - 1));

   // Next-state and next-value logic for the play FSM, timer and clear queue.
   always_comb begin
      w_state_nxt     = r_state;
      w_collected_nxt = r_collected;
      w_pending_nxt   = w_pending_drained;
      w_seconds_nxt   = r_seconds;
      w_tick_nxt      = r_tick;
      w_restore_nxt   = 1'b0;
      w_cause_nxt     = r_lose_cause;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt   = S_PLAY;
               w_seconds_nxt = SEC_W'(TIME_LIMIT);
               w_tick_nxt    = '0;
               w_cause_nxt   = 1'b0;
            end
         end
         S_PLAY: begin
            w_collected_nxt = w_coll_merged;
            w_pending_nxt   = w_pending_drained | w_new;
            if (w_tick_wrap) begin
               w_tick_nxt    = '0;
               w_seconds_nxt = r_seconds - SEC_W'(1);
            end else begin
               w_tick_nxt    = r_tick + TICK_W'(1);
            end
            // Hazard beats timeout, timeout beats a simultaneous win.
            if (|hazard_hit) begin
               w_state_nxt = S_LOST;
               w_cause_nxt = 1'b1;
            end else if (w_tick_wrap && (r_seconds == SEC_W'(1))) begin
               w_state_nxt = S_LOST;
               w_cause_nxt = 1'b0;
            end else if (&w_coll_merged) begin
               w_state_nxt = S_WON;
            end
         end
         default: begin
            // WON/LOST are terminal until a restart; only the queue keeps draining.
            if (start) begin
               w_state_nxt     = S_PLAY;
               w_collected_nxt = '0;
               w_pending_nxt   = '0;
               w_seconds_nxt   = SEC_W'(TIME_LIMIT);
               w_tick_nxt      = '0;
               w_cause_nxt     = 1'b0;
               w_restore_nxt   = 1'b1;
            end
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_collected  <= '0;
         r_pending    <= '0;
         r_seconds    <= SEC_W'(TIME_LIMIT);
         r_tick       <= '0;
         r_restore    <= 1'b0;
         r_lose_cause <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_collected  <= w_collected_nxt;
         r_pending    <= w_pending_nxt;
         r_seconds    <= w_seconds_nxt;
         r_tick       <= w_tick_nxt;
         r_restore    <= w_restore_nxt;
         r_lose_cause <= w_cause_nxt;
      end
   end

   assign restore         = r_restore;
   assign collected       = r_collected;
   assign coins_remaining = CNT_W'(NUM_COINS) - f_popcount(r_collected);
   assign seconds_left    = r_seconds;
   assign state           = r_state;
   assign win             = (r_state == S_WON);
   assign lose            = (r_state == S_LOST);
   assign lose_cause      = r_lose_cause;

endmodule
